ssb_in: RTL and testbench
=========================

Name: ssb_in

Overview:
- Single-sideband receive mixer and decimator: the receive-side counterpart of the SSB DAC upconverter.
- Multiplies one signed ADC sample per clk by the rot_dds LO (cosa, sina) and integrates over the 4-state div_state window.
- Emits one interleaved I/Q pair per window (I then Q) on an 18-bit bus with a strobe, for downstream CIC/feedback logic.

Parameters:
dw, 16, ADC sample width (signed)
shift, 17, arithmetic right shift applied to the window sum before saturation

Ports:
clk  input  1  sample clock
reset  input  1  asynchronous, active-high; clears all state
div_state  input  2  phase counter shared with upconverter; window starts at 0, ends at 3
adc  input  dw  signed ADC sample
enable  input  1  0 = suppress output, clear accumulators
ssb_flip  input  1  1 = negate Q (sideband select)
cosa  input  18  signed LO cosine from rot_dds
sina  input  18  signed LO sine from rot_dds
iq_out  output  18  signed result, I when iq_sel=0, Q when iq_sel=1
iq_strobe  output  1  iq_out valid this cycle
iq_sel  output  1  0 = I, 1 = Q
overflow  output  1  sticky saturation flag
clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-high): iq_out=0, iq_strobe=0, iq_sel=0, overflow=0; products, accumulators, hold regs, tags and win_ok cleared.
- Stage 0, cycle n: adc, cosa, sina, div_state sampled.
- Stage 1, cycle n+1:
  - p_i = adc*cosa, p_q = adc*sina; 34-bit signed, registered.
  - p_q negated when ssb_flip=1; negation of the most negative product must not wrap (use 35-bit intermediate).
  - Tag ds1 = div_state; en1 = enable.
- Stage 2, cycle n+2:
  - 36-bit signed accumulators.
  - If ds1==0: acc <= p; else acc <= acc + p.
  - If en1==0: acc <= 0 and win_ok <= 0.
  - win_ok <= 1 when ds1==0 and en1==1. It stays 1 through ds1==1..3 only if en1 stays 1.
- Dump, cycle n+3, after ds1==3 with win_ok=1 and en1=1:
  - Scale each sum: s = acc >>> shift (floor, no rounding).
  - Saturate s to [-131072, 131071]. Any clip sets overflow.
  - Latch both results into hold regs.
  - Drive iq_out=I_sat, iq_sel=0, iq_strobe=1.
- Dump + 1 cycle: iq_out=Q_sat, iq_sel=1, iq_strobe=1.
- All other cycles: iq_strobe=0, iq_sel=0; iq_out holds its last value.
- Latency: adc sample at div_state==3 (cycle n) → I strobe at n+3, Q strobe at n+4. Pairs repeat every 4 cycles.
- Partial windows: reset or enable deassertion mid-window discards that window, with no strobe. The first strobe after recovery requires a complete 0..3 sequence seen at stage 1.
- div_state irregularity: a skipped value is not detected. A restart at 0 reinitialises the accumulators, and only a window ending in 3 with win_ok dumps.
- overflow:
  - Sticky until clear_ovf=1 (synchronous) or reset.
  - If clear_ovf and a new saturation occur in the same cycle, set wins.
- ssb_flip and enable are sampled per sample at stage 0, not per window.

Test Plan:
- div_state free-running 0..3; adc=1000, cosa=65536, sina=0 → I=2000, Q=0. Strobes exactly 3 and 4 cycles after the div_state==3 sample, period 4; overflow=0.
- adc=1000, cosa=0, sina=65536, ssb_flip=0 → Q=2000. With ssb_flip=1 → Q=-2000; I=0 in both cases.
- Saturation: adc=-32768, cosa=-131072 → sum 17179869184, scaled 131072 → iq_out I=131071, overflow=1. Overflow stays 1 after adc returns to 1000; clear_ovf pulse → 0.
- Floor check: adc=-1, cosa=1 → sum -4 → I=-1 (not 0); adc=1, cosa=1 → I=0.
- Reset asserted asynchronously with div_state==2 mid-window → iq_out=0, iq_strobe=0 immediately. After release, no strobe until a full 0..3 window completes, then I=2000 with the first-test stimulus.
- enable dropped for one cycle at div_state==1 → that window produces no strobe. The next full window with enable=1 yields a normal pair.

Source files
------------

// File: rtl/ssb_in.sv
// SSB receive mixer/decimator: multiplies ADC samples by the rot_dds LO, integrates over
// each 4-sample div_state window and emits an interleaved, saturated I/Q pair per window.
module ssb_in #(
  parameter int dw    = 16,
  parameter int shift = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           div_state,
  input  logic signed [dw-1:0] adc,
  input  logic                 enable,
  input  logic                 ssb_flip,
  input  logic signed [17:0]   cosa,
  input  logic signed [17:0]   sina,
  output logic signed [17:0]   iq_out,
  output logic                 iq_strobe,
  output logic                 iq_sel,
  output logic                 overflow,
  input  logic                 clear_ovf
);

  localparam int pw = dw + 18;
  localparam int aw = pw + 2;
  localparam logic signed [aw-1:0] sat_hi = aw'(32'sd131071);
  localparam logic signed [aw-1:0] sat_lo = aw'(-32'sd131072);

  // Bit 18 flags a clip; bits 17:0 carry the saturated value.
  function automatic logic [18:0] sat18(input logic signed [aw-1:0] v);
    logic [18:0] r;
    if (v > sat_hi) begin
      r = {1'b1, 18'h1FFFF};
    end else if (v < sat_lo) begin
      r = {1'b1, 18'h20000};
    end else begin
      r = {1'b0, v[17:0]};
    end
    return r;
  endfunction

  logic signed [pw-1:0] p_i_d, p_q_raw, p_i_q;
  logic signed [pw:0]   p_q_d, p_q_q;
  logic [1:0]           ds1_q;
  logic                 en1_q;
  logic signed [aw-1:0] acc_i_d, acc_q_d, acc_i_q, acc_q_q;
  logic                 win_ok_d, win_ok_q, last_d, last_q;
  logic signed [aw-1:0] sc_i, sc_q;
  logic [18:0]          sat_i, sat_q;
  logic                 ovf_d, ovf_q;
  logic signed [17:0]   iq_out_q, hold_q_q;
  logic                 strobe_q, sel_q, q_pend_q;

  // Mixer products; the Q product gets one extra bit so negation cannot wrap.
  always_comb begin
    p_i_d   = pw'(adc) * pw'(cosa);
    p_q_raw = pw'(adc) * pw'(sina);
    if (ssb_flip) begin
      p_q_d = -((pw+1)'(p_q_raw));
    end else begin
      p_q_d = (pw+1)'(p_q_raw);
    end
  end

  // Window integration: restart at phase 0, any disabled sample kills the window.
  always_comb begin
    if (!en1_q) begin
      acc_i_d  = {aw{1'b0}};
      acc_q_d  = {aw{1'b0}};
      win_ok_d = 1'b0;
    end else if (ds1_q == 2'd0) begin
      acc_i_d  = aw'(p_i_q);
      acc_q_d  = aw'(p_q_q);
      win_ok_d = 1'b1;
    end else begin
      acc_i_d  = acc_i_q + aw'(p_i_q);
      acc_q_d  = acc_q_q + aw'(p_q_q);
      win_ok_d = win_ok_q;
    end
    last_d = en1_q && win_ok_d && (ds1_q == 2'd3);
  end

  // Scale (floor) and saturate the completed window; a new clip beats clear_ovf.
  always_comb begin
    sc_i  = acc_i_q >>> shift;
    sc_q  = acc_q_q >>> shift;
    sat_i = sat18(sc_i);
    sat_q = sat18(sc_q);
    if (last_q && (sat_i[18] || sat_q[18])) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline stages 1 and 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_i_q    <= '0;
      p_q_q    <= '0;
      ds1_q    <= 2'd0;
      en1_q    <= 1'b0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      win_ok_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      p_i_q    <= p_i_d;
      p_q_q    <= p_q_d;
      ds1_q    <= div_state;
      en1_q    <= enable;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      win_ok_q <= win_ok_d;
      last_q   <= last_d;
    end
  end

  // Output sequencer: I on the dump cycle, held Q on the following one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iq_out_q <= 18'sd0;
      hold_q_q <= 18'sd0;
      strobe_q <= 1'b0;
      sel_q    <= 1'b0;
      q_pend_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (last_q) begin
        iq_out_q <= sat_i[17:0];
        hold_q_q <= sat_q[17:0];
        strobe_q <= 1'b1;
        sel_q    <= 1'b0;
        q_pend_q <= 1'b1;
      end else if (q_pend_q) begin
        iq_out_q <= hold_q_q;
        strobe_q <= 1'b1;
        sel_q    <= 1'b1;
        q_pend_q <= 1'b0;
      end else begin
        strobe_q <= 1'b0;
        sel_q    <= 1'b0;
        q_pend_q <= 1'b0;
      end
    end
  end

  assign iq_out    = iq_out_q;
  assign iq_strobe = strobe_q;
  assign iq_sel    = sel_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ssb_in.sv
// Directed bench for ssb_in: each window drives div_state 0..3 and records the
// outputs seen at each step, which reflect the window before it.
module tb_ssb_in;
  logic               clk;
  logic               reset;
  logic [1:0]         div_state;
  logic signed [15:0] adc;
  logic               enable;
  logic               ssb_flip;
  logic signed [17:0] cosa;
  logic signed [17:0] sina;
  logic signed [17:0] iq_out;
  logic               iq_strobe;
  logic               iq_sel;
  logic               overflow;
  logic               clear_ovf;

  int checks = 0;
  int errors = 0;
  int ob_st [4];
  int ob_sel[4];
  int ob_out[4];
  int ob_ovf[4];

  ssb_in #(.dw(16), .shift(17)) dut (
    .clk(clk), .reset(reset), .div_state(div_state), .adc(adc), .enable(enable),
    .ssb_flip(ssb_flip), .cosa(cosa), .sina(sina), .iq_out(iq_out),
    .iq_strobe(iq_strobe), .iq_sel(iq_sel), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k, input int a, input int c, input int s,
                      input logic f, input logic e, input logic clr);
    @(negedge clk);
    ob_st[k]  = int'(iq_strobe);
    ob_sel[k] = int'(iq_sel);
    ob_out[k] = int'(iq_out);
    ob_ovf[k] = int'(overflow);
    div_state = 2'(k);
    adc       = 16'(a);
    cosa      = 18'(c);
    sina      = 18'(s);
    ssb_flip  = f;
    enable    = e;
    clear_ovf = clr;
  endtask

  task automatic window(input int a, input int c, input int s, input logic f,
                        input logic [3:0] en, input logic clr);
    for (int k = 0; k < 4; k++) begin
      step(k, a, c, s, f, en[k], (k == 0) ? clr : 1'b0);
    end
  endtask

  task automatic check_pair(input string tag, input int i_exp, input int q_exp);
    check({tag, "_st0"}, ob_st[0], 0);
    check({tag, "_st1"}, ob_st[1], 0);
    check({tag, "_i_st"}, ob_st[2], 1);
    check({tag, "_i_sel"}, ob_sel[2], 0);
    check({tag, "_i"}, ob_out[2], i_exp);
    check({tag, "_q_st"}, ob_st[3], 1);
    check({tag, "_q_sel"}, ob_sel[3], 1);
    check({tag, "_q"}, ob_out[3], q_exp);
  endtask

  task automatic check_none(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_nostb%0d", tag, k), ob_st[k], 0);
    end
  endtask

  initial begin
    reset = 1'b1; div_state = 2'd0; adc = 16'sd0; enable = 1'b1; ssb_flip = 1'b0;
    cosa = 18'sd0; sina = 18'sd0; clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", int'(iq_out), 0);
    check("rst_stb", int'(iq_strobe), 0);
    check("rst_sel", int'(iq_sel), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b0;

    // Basic I path and latency/period.
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_none("first");
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("basic", 2000, 0);
    check("basic_ovf", ob_ovf[3], 0);

    // Q path, both sidebands.
    window(1000, 0, 65536, 1'b0, 4'b1111, 1'b0);
    window(1000, 0, 65536, 1'b1, 4'b1111, 1'b0);
    check_pair("qpos", 0, 2000);
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("qneg", 0, -2000);

    // Saturation, sticky overflow, clear.
    window(-32768, -131072, 0, 1'b0, 4'b1111, 1'b0);
    check("hold_out", ob_out[0], -2000);
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("sat", 131071, 0);
    check("sat_ovf_pre", ob_ovf[1], 0);
    check("sat_ovf", ob_ovf[3], 1);
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("after_sat", 2000, 0);
    check("ovf_sticky", ob_ovf[3], 1);
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b1);
    check("ovf_clr", ob_ovf[1], 0);
    check("ovf_clr_stay", ob_ovf[3], 0);

    // Floor behaviour of the scaling shift.
    window(-1, 1, 0, 1'b0, 4'b1111, 1'b0);
    window(1, 1, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("floor_neg", -1, 0);
    window(1000, 65536, 65536, 1'b0, 4'b1111, 1'b0);
    check_pair("floor_pos", 0, 0);

    // Asynchronous reset mid-window.
    window(1000, 65536, 65536, 1'b0, 4'b1111, 1'b0);
    check_pair("iq_both", 2000, 2000);
    step(0, 1000, 65536, 65536, 1'b0, 1'b1, 1'b0);
    step(1, 1000, 65536, 65536, 1'b0, 1'b1, 1'b0);
    step(2, 1000, 65536, 65536, 1'b0, 1'b1, 1'b0);
    check("pre_rst_stb", ob_st[2], 1);
    check("pre_rst_out", ob_out[2], 2000);
    #2 reset = 1'b1;
    #1;
    check("arst_out", int'(iq_out), 0);
    check("arst_stb", int'(iq_strobe), 0);
    repeat (2) @(negedge clk);
    step(3, 1000, 65536, 0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_none("post_rst");
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("recover", 2000, 0);

    // Enable dropped for one sample at phase 1.
    window(1000, 65536, 0, 1'b0, 4'b1101, 1'b0);
    check_pair("pre_en", 2000, 0);
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_none("en_drop");
    window(1000, 65536, 0, 1'b0, 4'b1111, 1'b0);
    check_pair("en_recover", 2000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
